// File: rtl/mem_multicycle_param.sv
// Single-port multi-cycle memory with start/ready handshake, fixed or address-derived
// latency, a load port usable while idle, and combinational debug read taps.
module mem_multicycle_param #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 8,
    parameter int LAT_MODE  = 1,
    parameter int FIXED_LAT = 2,
    parameter int LAT_BITS  = 2,
    parameter int N_DBG     = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      rwn,
    input  logic [ADDR_W-1:0]         address,
    input  logic [DATA_W-1:0]         data_in,
    output logic                      ready,
    output logic [DATA_W-1:0]         data_out,
    output logic                      rd_valid,
    output logic                      collision,
    input  logic                      ld_we,
    input  logic [ADDR_W-1:0]         ld_addr,
    input  logic [DATA_W-1:0]         ld_data,
    input  logic [N_DBG*ADDR_W-1:0]   dbg_addr,
    output logic [N_DBG*DATA_W-1:0]   dbg_data
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t              state, state_nx;
    logic [LAT_BITS-1:0] count, count_nx, lat_sel;
    logic                accept;

    logic                req_rwn;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_data;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_wa;
    logic [DATA_W-1:0]   mem_wd;

    // Wait count is the number of extra cycles spent in WAIT before the access.
    assign lat_sel = (LAT_MODE != 0) ? address[LAT_BITS-1:0] : LAT_BITS'(FIXED_LAT);
    assign ready   = (state == IDLE);

    always_comb begin
        state_nx = state;
        count_nx = count;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    count_nx = lat_sel;
                    state_nx = (lat_sel != '0) ? WAIT : DONE;
                end
            end
            WAIT: begin
                count_nx = count - LAT_BITS'(1);
                if (count == LAT_BITS'(1)) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            data_out  <= '0;
            rd_valid  <= 1'b0;
            collision <= 1'b0;
        end else begin
            state     <= state_nx;
            count     <= count_nx;
            rd_valid  <= (state == DONE) && req_rwn;
            collision <= start && (state != IDLE);
            if ((state == DONE) && req_rwn) data_out <= mem[req_addr];
        end
    end

    // Request capture is pure datapath; reset only needs to clear the FSM.
    always_ff @(posedge clk) begin
        if (accept) begin
            req_rwn  <= rwn;
            req_addr <= address;
            req_data <= data_in;
        end
    end

    // DONE and IDLE are exclusive, so the request write and the load port never collide.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = ld_addr;
        mem_wd = ld_data;
        if ((state == DONE) && !req_rwn) begin
            mem_we = 1'b1;
            mem_wa = req_addr;
            mem_wd = req_data;
        end else if ((state == IDLE) && ld_we) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    for (genvar k = 0; k < N_DBG; k++) begin : g_dbg
        assign dbg_data[k*DATA_W +: DATA_W] = mem[dbg_addr[k*ADDR_W +: ADDR_W]];
    end

endmodule

// File: tb/tb_mem_multicycle_param.sv
// Bench for mem_multicycle_param: table vectors, hand-written corner sequences and
// randomized transactions against a transaction-level memory model.
module tb_mem_multicycle_param;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int ND = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              start, start_f, rwn;
    logic [AW-1:0]     address;
    logic [DW-1:0]     data_in;
    logic              ld_we;
    logic [AW-1:0]     ld_addr;
    logic [DW-1:0]     ld_data;
    logic [ND*AW-1:0]  dbg_addr;

    logic              ready, rd_valid, collision;
    logic [DW-1:0]     data_out;
    logic [ND*DW-1:0]  dbg_data;
    logic              ready_f, rd_valid_f, collision_f;
    logic [DW-1:0]     data_out_f;
    logic [ND*DW-1:0]  dbg_data_f;

    always #5 clk = ~clk;

    mem_multicycle_param #(.DATA_W(DW), .ADDR_W(AW), .LAT_MODE(1), .FIXED_LAT(2),
                           .LAT_BITS(2), .N_DBG(ND)) u_dut (
        .clk(clk), .reset(reset), .start(start), .rwn(rwn), .address(address),
        .data_in(data_in), .ready(ready), .data_out(data_out), .rd_valid(rd_valid),
        .collision(collision), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data));

    mem_multicycle_param #(.DATA_W(DW), .ADDR_W(AW), .LAT_MODE(0), .FIXED_LAT(2),
                           .LAT_BITS(2), .N_DBG(ND)) u_fix (
        .clk(clk), .reset(reset), .start(start_f), .rwn(rwn), .address(address),
        .data_in(data_in), .ready(ready_f), .data_out(data_out_f), .rd_valid(rd_valid_f),
        .collision(collision_f), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data_f));

    typedef struct {
        logic          rwn;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            spam;   // cycles start stays high after accept
        int            lat;    // expected wait count
        int            ldm;    // 0 none, 1 load while busy, 2 load together with start
        logic [DW-1:0] ldv;
        logic [DW-1:0] exp;    // expected read data
    } vec_t;

    int            tests  = 0;
    int            failed = 0;
    logic [DW-1:0] mem_m [256];
    logic [DW-1:0] dout_m = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ld_we = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_we = 1'b0;
        mem_m[a] = d;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50 && !ready; i++) @(negedge clk);
        check("idle_wait", {31'd0, ready}, 32'd1);
    endtask

    task automatic transact(input vec_t v);
        wait_idle();
        address = v.addr; rwn = v.rwn; data_in = v.data; start = 1'b1;
        dbg_addr[AW-1:0] = v.addr;
        if (v.ldm == 2) begin
            ld_we = 1'b1; ld_addr = v.addr; ld_data = v.ldv;
            mem_m[v.addr] = v.ldv;
        end
        for (int k = 0; k <= v.lat + 1; k++) begin
            @(negedge clk);
            check("ready", {31'd0, ready}, {31'd0, k == v.lat + 1});
            check("rd_valid", {31'd0, rd_valid}, {31'd0, (k == v.lat + 1) && v.rwn});
            check("collision", {31'd0, collision}, {31'd0, (k >= 1) && (k <= v.spam)});
            if (k == v.lat + 1) begin
                if (v.rwn) begin
                    check("read_data", {16'd0, data_out}, {16'd0, v.exp});
                    dout_m = v.exp;
                end else begin
                    check("dout_hold", {16'd0, data_out}, {16'd0, dout_m});
                    check("dbg_after_wr", {16'd0, dbg_data[DW-1:0]}, {16'd0, v.data});
                    mem_m[v.addr] = v.data;
                end
            end
            start = (k < v.spam);
            ld_we = 1'b0;
            if (v.ldm == 1 && k == 0) begin
                ld_we = 1'b1; ld_addr = v.addr; ld_data = v.ldv;
            end
        end
        start = 1'b0; ld_we = 1'b0;
    endtask

    vec_t tbl [9];
    vec_t rv;

    initial begin
        tbl[0] = '{1'b1, 8'hF5, 16'h0000, 0, 1, 0, 16'h0000, 16'h0008};
        tbl[1] = '{1'b0, 8'hF8, 16'h1234, 0, 0, 0, 16'h0000, 16'h0000};
        tbl[2] = '{1'b1, 8'hF8, 16'h0000, 0, 0, 0, 16'h0000, 16'h1234};
        tbl[3] = '{1'b1, 8'h03, 16'h0000, 3, 3, 0, 16'h0000, 16'hA503};
        tbl[4] = '{1'b1, 8'h21, 16'h0000, 0, 1, 2, 16'h7777, 16'h7777};
        tbl[5] = '{1'b1, 8'h22, 16'h0000, 1, 2, 1, 16'hDEAD, 16'hA522};
        tbl[6] = '{1'b0, 8'h42, 16'hCAFE, 2, 2, 0, 16'h0000, 16'h0000};
        tbl[7] = '{1'b1, 8'h42, 16'h0000, 1, 2, 0, 16'h0000, 16'hCAFE};
        tbl[8] = '{1'b1, 8'h22, 16'h0000, 0, 2, 0, 16'h0000, 16'hA522};

        reset = 1'b1; start = 1'b0; start_f = 1'b0; rwn = 1'b1; address = '0;
        data_in = '0; ld_we = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_dout", {16'd0, data_out}, 32'd0);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_collision", {31'd0, collision}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int a = 0; a < 256; a++) load_word(AW'(a), {8'hA5, 8'(a)});
        load_word(8'hF5, 16'h0008);

        for (int i = 0; i < 9; i++) transact(tbl[i]);

        // Reset in the middle of a pending write to 0x07 (wait count 3).
        wait_idle();
        address = 8'h07; rwn = 1'b0; data_in = 16'hBEEF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_ready", {31'd0, ready}, 32'd1);
        check("mid_rst_dout", {16'd0, data_out}, 32'd0);
        check("mid_rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        dout_m = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_rd_valid", {31'd0, rd_valid}, 32'd0);
            check("post_rst_ready", {31'd0, ready}, 32'd1);
        end
        dbg_addr[AW-1:0] = 8'h07;
        #1 check("rst_no_write", {16'd0, dbg_data[DW-1:0]}, 32'h0000A507);
        transact('{1'b1, 8'h07, 16'h0000, 0, 3, 0, 16'h0000, 16'hA507});

        // Fixed-latency instance: every address waits FIXED_LAT cycles.
        for (int j = 0; j < 2; j++) begin
            address = (j == 0) ? 8'h00 : 8'hFF; rwn = 1'b1; start_f = 1'b1;
            check("fix_ready_pre", {31'd0, ready_f}, 32'd1);
            for (int k = 0; k <= 3; k++) begin
                @(negedge clk);
                start_f = 1'b0;
                check("fix_ready", {31'd0, ready_f}, {31'd0, k == 3});
                check("fix_rd_valid", {31'd0, rd_valid_f}, {31'd0, k == 3});
            end
            check("fix_data", {16'd0, data_out_f}, (j == 0) ? 32'h0000A500 : 32'h0000A5FF);
        end

        // Randomized transactions against the model.
        for (int n = 0; n < 60; n++) begin
            rv.rwn  = 1'($urandom_range(0, 1));
            rv.addr = AW'($urandom_range(0, 255));
            rv.data = DW'($urandom);
            rv.lat  = int'(rv.addr) % 4;
            rv.spam = $urandom_range(0, rv.lat + 1);
            rv.ldm  = $urandom_range(0, 2);
            rv.ldv  = DW'($urandom);
            rv.exp  = (rv.ldm == 2) ? rv.ldv : mem_m[rv.addr];
            transact(rv);
            if (n % 10 == 0) begin
                dbg_addr = ND*AW'({$urandom, $urandom});
                #1;
                for (int t = 0; t < ND; t++)
                    check("dbg_tap", {16'd0, dbg_data[t*DW +: DW]},
                          {16'd0, mem_m[dbg_addr[t*AW +: AW]]});
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
